// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
package i2c_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [1:0] RSP_ACK   = 2'b00;
  localparam logic [1:0] RSP_NACK  = 2'b01;
  localparam logic [1:0] RSP_TO    = 2'b10;
  localparam logic [1:0] RSP_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_HOLD,
    ST_ABORT_ISSUE,
    ST_ABORT_WAIT
  } state_e;

  typedef struct packed {
    logic              start;
    logic              stop;
    logic              rw;
    logic [BYTE_W-1:0] data;
  } cmd_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Extract requester idx's command fields from the packed request vectors.
  function automatic cmd_t pick_cmd(input logic [NUM_REQ-1:0]        st,
                                    input logic [NUM_REQ-1:0]        sp,
                                    input logic [NUM_REQ-1:0]        rw,
                                    input logic [NUM_REQ*BYTE_W-1:0] data,
                                    input logic                      idx);
    cmd_t c;
    c.start = st[idx];
    c.stop  = sp[idx];
    c.rw    = rw[idx];
    c.data  = idx ? data[2*BYTE_W-1:BYTE_W] : data[BYTE_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester command/response bus plus the byte-engine control bus.
interface i2c_master_arbiter_if;
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_start;
  logic [NUM_REQ-1:0]        req_stop;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [1:0]                rsp_status;
  logic [BYTE_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      m_start;
  logic                      m_stop;
  logic                      m_rw;
  logic [BYTE_W-1:0]         m_dataW;
  logic                      m_go;
  logic                      m_ack;
  logic                      m_nack;
  logic                      m_to;
  logic [BYTE_W-1:0]         m_dataR;
  logic                      m_busy;

  modport master (
    input  req_valid, req_start, req_stop, req_rw, req_data,
    input  m_ack, m_nack, m_to, m_dataR, m_busy,
    output req_ready, rsp_valid, rsp_status, rsp_data, grant,
    output m_start, m_stop, m_rw, m_dataW, m_go
  );

  modport slave (
    output req_valid, req_start, req_stop, req_rw, req_data,
    output m_ack, m_nack, m_to, m_dataR, m_busy,
    input  req_ready, rsp_valid, rsp_status, rsp_data, grant,
    input  m_start, m_stop, m_rw, m_dataW, m_go
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the requester that did not own the bus last wins.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       pick_valid_c,
  output logic       pick_idx_c
);
  always_comb begin
    pick_valid_c = |req_i;
    pick_idx_c   = (&req_i) ? ~last_i : req_i[1];
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one byte-level I2C master engine between two requesters, one whole transaction at a time,
// and forces a STOP itself after a mid-transaction NACK or an idle holder.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  i2c_master_arbiter_if.master bus
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [BYTE_W-1:0]     rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]    bad_q, bad_d;
  logic                  m_go_q, m_go_d;
  logic                  m_start_q, m_start_d;
  logic                  m_stop_q, m_stop_d;
  logic                  m_rw_q, m_rw_d;
  logic [BYTE_W-1:0]     m_dataw_q, m_dataw_d;

  logic [NUM_REQ-1:0]    eligible, good_req, bad_req;
  logic                  pick_valid, pick_idx, holder, any_done;

  // A requester whose ready pulse is on the bus right now is completing its handshake; don't re-accept.
  assign eligible = bus.req_valid & ~req_ready_q;
  assign good_req = eligible & bus.req_start;
  assign bad_req  = eligible & ~bus.req_start;
  assign holder   = grant_q[1];
  assign any_done = bus.m_ack | bus.m_nack | bus.m_to;

  rr_arbiter_2 u_rr (
    .req_i        (good_req),
    .last_i       (last_q),
    .pick_valid_c (pick_valid),
    .pick_idx_c   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    bad_d        = '0;
    rsp_valid_d  = bad_q;
    rsp_status_d = (|bad_q) ? RSP_ABORT : rsp_status_q;
    rsp_data_d   = rsp_data_q;
    m_go_d       = 1'b0;
    m_start_d    = m_start_q;
    m_stop_d     = m_stop_q;
    m_rw_d       = m_rw_q;
    m_dataw_d    = m_dataw_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.m_busy) begin
          if (pick_valid) begin
            req_ready_d = onehot(pick_idx);
            grant_d     = onehot(pick_idx);
            cmd_d       = pick_cmd(bus.req_start, bus.req_stop, bus.req_rw, bus.req_data, pick_idx);
            state_d     = ST_ISSUE;
          end else if (bad_req[0]) begin
            req_ready_d = 2'b01;
            bad_d       = 2'b01;
          end else if (bad_req[1]) begin
            req_ready_d = 2'b10;
            bad_d       = 2'b10;
          end
        end
      end
      ST_ISSUE: begin
        m_go_d    = 1'b1;
        m_start_d = cmd_q.start;
        m_stop_d  = cmd_q.stop;
        m_rw_d    = cmd_q.rw;
        m_dataw_d = cmd_q.data;
        state_d   = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (bus.m_to) begin
          rsp_valid_d  = onehot(holder);
          rsp_status_d = RSP_TO;
          grant_d      = '0;
          last_d       = holder;
          state_d      = ST_IDLE;
        end else if (bus.m_nack) begin
          rsp_valid_d  = onehot(holder);
          rsp_status_d = RSP_NACK;
          if (cmd_q.stop) begin
            grant_d = '0;
            last_d  = holder;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ABORT_ISSUE;
          end
        end else if (bus.m_ack) begin
          rsp_valid_d  = onehot(holder);
          rsp_status_d = RSP_ACK;
          rsp_data_d   = bus.m_dataR;
          if (cmd_q.stop) begin
            grant_d = '0;
            last_d  = holder;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Holder's next byte beats the timeout when both land in the same cycle.
        if (eligible[holder] && !bus.m_busy) begin
          req_ready_d = onehot(holder);
          cmd_d       = pick_cmd(bus.req_start, bus.req_stop, bus.req_rw, bus.req_data, holder);
          cnt_d       = '0;
          state_d     = ST_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d  = onehot(holder);
          rsp_status_d = RSP_ABORT;
          state_d      = ST_ABORT_ISSUE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ABORT_ISSUE: begin
        m_go_d    = 1'b1;
        m_start_d = 1'b0;
        m_stop_d  = 1'b1;
        m_rw_d    = 1'b0;
        m_dataw_d = '0;
        state_d   = ST_ABORT_WAIT;
      end
      ST_ABORT_WAIT: begin
        if (any_done) begin
          grant_d = '0;
          last_d  = holder;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      grant_q      <= '0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      bad_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      m_go_q       <= 1'b0;
      m_start_q    <= 1'b0;
      m_stop_q     <= 1'b0;
      m_rw_q       <= 1'b0;
      m_dataw_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      bad_q        <= bad_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      m_go_q       <= m_go_d;
      m_start_q    <= m_start_d;
      m_stop_q     <= m_stop_d;
      m_rw_q       <= m_rw_d;
      m_dataw_q    <= m_dataw_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.grant      = grant_q;
  assign bus.m_go       = m_go_q;
  assign bus.m_start    = m_start_q;
  assign bus.m_stop     = m_stop_q;
  assign bus.m_rw       = m_rw_q;
  assign bus.m_dataW    = m_dataw_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: the bench plays both requesters and the byte engine.
module tb_i2c_master_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  i2c_master_arbiter_if bus ();

  i2c_master_arbiter #(.HOLD_TIMEOUT(8)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_start = '0;
    bus.req_stop  = '0;
    bus.req_rw    = '0;
    bus.req_data  = '0;
    bus.m_ack     = 1'b0;
    bus.m_nack    = 1'b0;
    bus.m_to      = 1'b0;
    bus.m_dataR   = '0;
    bus.m_busy    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic st, input logic sp, input logic rw, input logic [7:0] d);
    bus.req_start[idx]       = st;
    bus.req_stop[idx]        = sp;
    bus.req_rw[idx]          = rw;
    bus.req_data[8*idx +: 8] = d;
    bus.req_valid[idx]       = 1'b1;
  endtask

  // Present a command, wait (bounded) for its ready pulse, complete the handshake; returns one cycle later.
  task automatic send(input int idx, input logic st, input logic sp, input logic rw,
                      input logic [7:0] d, output bit got);
    got = 1'b0;
    set_req(idx, st, sp, rw, d);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.req_ready[idx]) begin
        got = 1'b1;
        break;
      end
    end
    tick();
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic engine(input bit a, input bit n, input bit t, input logic [7:0] d);
    bus.m_ack   = a;
    bus.m_nack  = n;
    bus.m_to    = t;
    bus.m_dataR = d;
    tick();
    bus.m_ack  = 1'b0;
    bus.m_nack = 1'b0;
    bus.m_to   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    do_reset();
    outs = {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_data, bus.grant,
            bus.m_go, bus.m_start, bus.m_stop, bus.m_rw, bus.m_dataW};
    n_cmp++;
    if (outs !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    // Engine pulse while idle must be ignored.
    engine(1'b1, 1'b0, 1'b0, 8'hEE);
    n_cmp++;
    if (bus.rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL idle_ack_ignored rsp_valid=%b exp=00", bus.rsp_valid);
    end
  endtask

  task automatic test_write_two_bytes();
    bit got;
    do_reset();
    send(0, 1'b1, 1'b0, 1'b0, 8'h50, got);
    n_cmp++;
    if (!got || bus.m_go !== 1'b1 || bus.m_dataW !== 8'h50 || bus.m_start !== 1'b1 ||
        bus.m_stop !== 1'b0 || bus.grant !== 2'b01) begin
      n_err++;
      $display("FAIL t1_first_go got=%0b go=%b dataW=%h start=%b stop=%b grant=%b exp 1 1 50 1 0 01",
               got, bus.m_go, bus.m_dataW, bus.m_start, bus.m_stop, bus.grant);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_status !== 2'b00 || bus.grant !== 2'b01) begin
      n_err++;
      $display("FAIL t1_first_rsp valid=%b status=%b grant=%b exp 01 00 01",
               bus.rsp_valid, bus.rsp_status, bus.grant);
    end
    send(0, 1'b0, 1'b1, 1'b0, 8'hA5, got);
    n_cmp++;
    if (!got || bus.m_go !== 1'b1 || bus.m_dataW !== 8'hA5 || bus.m_start !== 1'b0 ||
        bus.m_stop !== 1'b1) begin
      n_err++;
      $display("FAIL t1_second_go got=%0b go=%b dataW=%h start=%b stop=%b exp 1 1 a5 0 1",
               got, bus.m_go, bus.m_dataW, bus.m_start, bus.m_stop);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_status !== 2'b00 || bus.grant !== 2'b00 || bus.m_go !== 1'b0) begin
      n_err++;
      $display("FAIL t1_second_rsp valid=%b status=%b grant=%b go=%b exp 01 00 00 0",
               bus.rsp_valid, bus.rsp_status, bus.grant, bus.m_go);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h01);
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    n_cmp++;
    if (bus.req_ready !== 2'b01 || bus.grant !== 2'b01) begin
      n_err++;
      $display("FAIL t2_first_tie ready=%b grant=%b exp 01 01", bus.req_ready, bus.grant);
    end
    tick();
    bus.req_valid[0] = 1'b0;
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h03);
    tick();
    n_cmp++;
    if (bus.req_ready !== 2'b10 || bus.grant !== 2'b10) begin
      n_err++;
      $display("FAIL t2_second_tie ready=%b grant=%b exp 10 10", bus.req_ready, bus.grant);
    end
    tick();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.m_go !== 1'b1 || bus.m_dataW !== 8'h02) begin
      n_err++;
      $display("FAIL t2_second_go go=%b dataW=%h exp 1 02", bus.m_go, bus.m_dataW);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_read();
    bit got;
    do_reset();
    send(1, 1'b1, 1'b1, 1'b1, 8'h00, got);
    n_cmp++;
    if (!got || bus.m_rw !== 1'b1 || bus.grant !== 2'b10 || bus.m_go !== 1'b1) begin
      n_err++;
      $display("FAIL t3_issue got=%0b rw=%b grant=%b go=%b exp 1 1 10 1", got, bus.m_rw, bus.grant, bus.m_go);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h3C);
    n_cmp++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_status !== 2'b00 || bus.rsp_data !== 8'h3C || bus.grant !== 2'b00) begin
      n_err++;
      $display("FAIL t3_rsp valid=%b status=%b data=%h grant=%b exp 10 00 3c 00",
               bus.rsp_valid, bus.rsp_status, bus.rsp_data, bus.grant);
    end
  endtask

  task automatic test_nack_recovery();
    bit got;
    do_reset();
    send(0, 1'b1, 1'b0, 1'b0, 8'h12, got);
    engine(1'b1, 1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (!got || bus.rsp_valid !== 2'b01 || bus.rsp_status !== 2'b01 || bus.grant !== 2'b01) begin
      n_err++;
      $display("FAIL t4_nack_rsp got=%0b valid=%b status=%b grant=%b exp 1 01 01 01",
               got, bus.rsp_valid, bus.rsp_status, bus.grant);
    end
    tick();
    n_cmp++;
    if (bus.m_go !== 1'b1 || bus.m_stop !== 1'b1 || bus.m_start !== 1'b0 || bus.m_dataW !== 8'h00) begin
      n_err++;
      $display("FAIL t4_forced_stop go=%b stop=%b start=%b dataW=%h exp 1 1 0 00",
               bus.m_go, bus.m_stop, bus.m_start, bus.m_dataW);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (bus.grant !== 2'b00 || bus.rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL t4_release grant=%b valid=%b exp 00 00", bus.grant, bus.rsp_valid);
    end
  endtask

  task automatic test_hold_timeout();
    bit got;
    do_reset();
    send(0, 1'b1, 1'b0, 1'b0, 8'h77, got);
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL t5_hold_idle_%0d valid=%b ready=%b exp 00 00", i, bus.rsp_valid, bus.req_ready);
      end
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_status !== 2'b11) begin
      n_err++;
      $display("FAIL t5_timeout_rsp valid=%b status=%b exp 01 11", bus.rsp_valid, bus.rsp_status);
    end
    tick();
    n_cmp++;
    if (bus.m_go !== 1'b1 || bus.m_stop !== 1'b1 || bus.m_start !== 1'b0) begin
      n_err++;
      $display("FAIL t5_forced_stop go=%b stop=%b start=%b exp 1 1 0", bus.m_go, bus.m_stop, bus.m_start);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (bus.grant !== 2'b00) begin
      n_err++;
      $display("FAIL t5_release grant=%b exp 00", bus.grant);
    end
    tick();
    n_cmp++;
    if (bus.req_ready !== 2'b10 || bus.grant !== 2'b10) begin
      n_err++;
      $display("FAIL t5_waiter_granted ready=%b grant=%b exp 10 10", bus.req_ready, bus.grant);
    end
    tick();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.m_go !== 1'b1 || bus.m_dataW !== 8'h99) begin
      n_err++;
      $display("FAIL t5_waiter_go go=%b dataW=%h exp 1 99", bus.m_go, bus.m_dataW);
    end
    engine(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_status !== 2'b00) begin
      n_err++;
      $display("FAIL t5_waiter_rsp valid=%b status=%b exp 10 00", bus.rsp_valid, bus.rsp_status);
    end
  endtask

  task automatic test_no_start();
    do_reset();
    set_req(1, 1'b0, 1'b1, 1'b0, 8'h44);
    tick();
    n_cmp++;
    if (bus.req_ready !== 2'b10 || bus.grant !== 2'b00) begin
      n_err++;
      $display("FAIL nostart_accept ready=%b grant=%b exp 10 00", bus.req_ready, bus.grant);
    end
    tick();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_status !== 2'b11 || bus.m_go !== 1'b0 || bus.req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL nostart_abort valid=%b status=%b go=%b ready=%b exp 10 11 0 00",
               bus.rsp_valid, bus.rsp_status, bus.m_go, bus.req_ready);
    end
  endtask

  task automatic test_timeout_and_reset();
    bit          got;
    logic [31:0] outs;
    do_reset();
    send(1, 1'b1, 1'b0, 1'b0, 8'h11, got);
    engine(1'b0, 1'b0, 1'b1, 8'h00);
    n_cmp++;
    if (!got || bus.rsp_valid !== 2'b10 || bus.rsp_status !== 2'b10 || bus.grant !== 2'b00) begin
      n_err++;
      $display("FAIL t6_to_rsp got=%0b valid=%b status=%b grant=%b exp 1 10 10 00",
               got, bus.rsp_valid, bus.rsp_status, bus.grant);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.m_go !== 1'b0) begin
        n_err++;
        $display("FAIL t6_no_stop_%0d go=%b exp 0", i, bus.m_go);
      end
    end
    send(0, 1'b1, 1'b1, 1'b1, 8'h22, got);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    outs = {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_data, bus.grant,
            bus.m_go, bus.m_start, bus.m_stop, bus.m_rw, bus.m_dataW};
    n_cmp++;
    if (!got || outs !== 32'h0) begin
      n_err++;
      $display("FAIL t6_reset_in_wait got=%0b outs=%h exp 1 0", got, outs);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_write_two_bytes();
    test_round_robin();
    test_read();
    test_nack_recovery();
    test_hold_timeout();
    test_no_start();
    test_timeout_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
